// File: rtl/conv_encode.sv
// -----------------------------------------------------------------------------
// conv_encode
//
// Rate-1/2 convolutional encoder for the BPSK transmit chain. It sits between
// the serial PN/data source and the BPSK mapper. Each enabled clock it takes
// one data bit and produces one registered 2-bit code symbol. The default
// generators are (7,5) octal with constraint length 3.
//
// Parameters:
//   K   - constraint length (>= 2); the shift register holds K-1 past bits.
//   G0  - generator for encode_sig[1]; MSB taps the current input bit.
//   G1  - generator for encode_sig[0]; MSB taps the current input bit.
//
// Ports:
//   clk_sig    in   1  clock; all state changes on the rising edge
//   rst_n      in   1  synchronous reset, ACTIVE-HIGH despite the name
//   q_sig      in   1  serial data bit, sampled on the rising edge
//   en_sig     in   1  active-low enable: 0 = encode one bit, 1 = hold
//   encode_sig out  2  registered code symbol {g0 output, g1 output}
//
// Flow control: there is no valid/ready handshake. en_sig low on a rising
// edge means "q_sig carries a bit, consume it"; the matching symbol appears on
// encode_sig after that same edge and stays until the next enabled edge or
// reset. en_sig high means no bit is consumed and nothing changes. The encoder
// can never back-pressure the source.
// -----------------------------------------------------------------------------
module conv_encode #(
  parameter int             K  = 3,
  parameter logic [K-1:0]   G0 = 3'b111,
  parameter logic [K-1:0]   G1 = 3'b101
) (
  input  logic       clk_sig,
  input  logic       rst_n,
  input  logic       q_sig,
  input  logic       en_sig,
  output logic [1:0] encode_sig
);

  // sr[0] is the previous input bit, sr[K-2] the oldest one kept.
  logic [K-2:0] sr;
  logic [K-2:0] sr_next;

  // Tap vector ordered to match the generator bit order:
  // tap_v[K-1] = current bit, tap_v[K-2] = sr[0], ..., tap_v[0] = sr[K-2].
  // This is the bit-reverse of the packed sr, so it is built explicitly.
  logic [K-1:0] tap_v;
  logic         c1;
  logic         c0;

  always_comb begin
    tap_v        = '0;
    tap_v[K-1]   = q_sig;
    for (int i = 0; i < K - 1; i++) begin
      tap_v[K-2-i] = sr[i];
    end

    c1 = ^(tap_v & G0);
    c0 = ^(tap_v & G1);

    // Shift towards the oldest position; written as a loop so that K = 2
    // (a one-bit register) needs no special-case slice.
    sr_next    = '0;
    sr_next[0] = q_sig;
    for (int i = 1; i < K - 1; i++) begin
      sr_next[i] = sr[i-1];
    end
  end

  // Reset beats enable; a held cycle leaves both state and output untouched,
  // so a stalled stream equals the un-stalled stream with the stalls removed.
  always_ff @(posedge clk_sig) begin
    if (rst_n) begin
      sr         <= '0;
      encode_sig <= 2'b00;
    end else if (!en_sig) begin
      sr         <= sr_next;
      encode_sig <= {c1, c0};
    end
  end

endmodule

// File: tb/tb_conv_encode.sv
// -----------------------------------------------------------------------------
// tb_conv_encode
//
// Bench for conv_encode with default (7,5) generators. The driver issues one
// input set per clock and queues the symbol expected after that edge; a
// separate monitor pops the queue on each falling edge and compares.
// -----------------------------------------------------------------------------
module tb_conv_encode;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk_sig = 1'b0;
  logic       rst_n   = 1'b1;
  logic       q_sig   = 1'b0;
  logic       en_sig  = 1'b1;
  logic [1:0] encode_sig;

  always #5 clk_sig = ~clk_sig;

  conv_encode dut (
    .clk_sig    (clk_sig),
    .rst_n      (rst_n),
    .q_sig      (q_sig),
    .en_sig     (en_sig),
    .encode_sig (encode_sig)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [1:0] exp_q[$];
  string      name_q[$];
  int         checks   = 0;
  int         failures = 0;

  // Monitor: the symbol for an edge is stable by the following falling edge.
  initial begin
    logic [1:0] exp_v;
    string      nm;
    forever begin
      @(negedge clk_sig);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        checks++;
        if (encode_sig !== exp_v) begin
          failures++;
          $display("FAIL %s: encode_sig=%b expected=%b at %0t", nm, encode_sig, exp_v, $time);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Apply inputs, let one rising edge consume them, queue the symbol expected
  // after that edge, then move off the edge before the next input change.
  task automatic step(input logic r, input logic e, input logic q,
                      input logic [1:0] exp_v, input string nm);
    rst_n  = r;
    en_sig = e;
    q_sig  = q;
    @(posedge clk_sig);
    exp_q.push_back(exp_v);
    name_q.push_back(nm);
    #1;
  endtask

  task automatic do_reset(input string nm);
    step(1'b1, 1'b0, 1'(($urandom_range(0, 1))), 2'b00, nm);
  endtask

  // Directed vector 1,0,1,1,0,0 and its hand-computed (7,5) symbols.
  logic       vec_q  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [1:0] vec_exp[6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};

  // PN source: 4-bit maximal LFSR (x^4 + x^3 + 1), period 15.
  logic [3:0] lfsr;
  logic       m_s0, m_s1;
  logic       pn_bit;
  logic [1:0] pn_exp;

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset for 2 cycles with random data; the first also has en_sig high,
    // reset must still win.
    step(1'b1, 1'b1, 1'(($urandom_range(0, 1))), 2'b00, "reset_en_hi");
    step(1'b1, 1'b0, 1'(($urandom_range(0, 1))), 2'b00, "reset_en_lo");

    // Known vector from the zero state.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, vec_q[i], vec_exp[i], "vector");

    // Same vector with a 3-cycle stall after the second bit.
    do_reset("reset_pre_stall");
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, vec_q[i], vec_exp[i], "stall_head");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'(($urandom_range(0, 1))), 2'b10, "stall_hold");
    for (int i = 2; i < 6; i++) step(1'b0, 1'b0, vec_q[i], vec_exp[i], "stall_tail");

    // All-zero input.
    do_reset("reset_pre_zero");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 2'b00, "all_zero");

    // All-one input: 11, 01, then 10 forever.
    do_reset("reset_pre_ones");
    step(1'b0, 1'b0, 1'b1, 2'b11, "all_one");
    step(1'b0, 1'b0, 1'b1, 2'b01, "all_one");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 2'b10, "all_one");

    // Mid-stream reset after 4 bits, then full replay from zero state.
    do_reset("reset_pre_mid");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, vec_q[i], vec_exp[i], "mid_first");
    do_reset("reset_mid");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, vec_q[i], vec_exp[i], "mid_replay");

    // PN source for 48 bits against an explicit (7,5) reference.
    do_reset("reset_pre_pn");
    lfsr = 4'b0001;
    m_s0 = 1'b0;
    m_s1 = 1'b0;
    for (int i = 0; i < 48; i++) begin
      pn_bit = lfsr[3];
      pn_exp = {pn_bit ^ m_s0 ^ m_s1, pn_bit ^ m_s1};
      step(1'b0, 1'b0, pn_bit, pn_exp, "pn_stream");
      m_s1 = m_s0;
      m_s0 = pn_bit;
      lfsr = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end
    en_sig = 1'b1;

    // Drain: bounded wait for the monitor to consume all queued symbols.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_sig);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    // ---------------------------------------------------------------------------
    // Final report
    // ---------------------------------------------------------------------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
